// File: rtl/bcd_comparator_serial.sv
// Serial MSD-first BCD magnitude comparator, one digit per clock with early exit.
// Optional invalid-digit detection is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_comparator_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic                  a_gt_b,
    output logic                  a_eq_b,
    output logic                  a_ge_b,
    output logic                  err
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] TOP_IDX = IW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPARE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [4*DIGITS-1:0]   r_a;
    logic [4*DIGITS-1:0]   r_b;
    logic [IW-1:0]         r_idx;
    logic                  r_gt;
    logic                  r_eq;
    logic [4*DIGITS-1:0]   w_sh_a;
    logic [4*DIGITS-1:0]   w_sh_b;
    logic [3:0]            w_dig_a;
    logic [3:0]            w_dig_b;
    logic                  w_diff;
    logic                  w_last;
    logic                  w_bad;

    // Current digit is brought down to the low nibble by shifting.
    assign w_sh_a  = r_a >> {r_idx, 2'b00};
    assign w_sh_b  = r_b >> {r_idx, 2'b00};
    assign w_dig_a = w_sh_a[3:0];
    assign w_dig_b = w_sh_b[3:0];
    assign w_diff  = (w_dig_a != w_dig_b);
    assign w_last  = (r_idx == '0);

`ifdef BCD_DIGIT_CHECK_EN
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                w_bad = 1'b1;
            end
        end
    end
`else
    assign w_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_bad ? S_DONE : S_COMPARE;
                end
            end
            S_COMPARE: begin
                busy = 1'b1;
                if (w_diff || w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_idx <= TOP_IDX;
                        r_gt  <= 1'b0;
                        r_eq  <= 1'b0;
                    end
                end
                S_COMPARE: begin
                    if (w_diff) begin
                        r_gt <= (w_dig_a > w_dig_b);
                        r_eq <= 1'b0;
                    end else if (w_last) begin
                        r_gt <= 1'b0;
                        r_eq <= 1'b1;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_err <= w_bad;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign a_gt_b = r_gt;
    assign a_eq_b = r_eq;
    assign a_ge_b = r_gt | r_eq;

endmodule
